// File: rtl/imm_encoder_pkg.sv
// rtl/imm_encoder_pkg.sv - shared core constants: format one-hots, opcodes, encoder states, li word builders
package imm_encoder_pkg;

    localparam logic [5:0] IT_R = 6'b100000;
    localparam logic [5:0] IT_I = 6'b010000;
    localparam logic [5:0] IT_S = 6'b001000;
    localparam logic [5:0] IT_B = 6'b000100;
    localparam logic [5:0] IT_U = 6'b000010;
    localparam logic [5:0] IT_J = 6'b000001;

    localparam logic [6:0] OP_LUI = 7'b0110111;
    localparam logic [6:0] OP_IMM = 7'b0010011;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_LI_LO = 1'b1
    } enc_state_e;

    // (imm + 0x800) >> 12 only needs imm[31:12] plus the carry out of imm[11]
    function automatic logic [31:0] lui_word(input logic [4:0] rd, input logic [20:0] imm_31_11);
        logic [19:0] hi;
        hi = imm_31_11[20:1] + {19'b0, imm_31_11[0]};
        return {hi, rd, OP_LUI};
    endfunction

    function automatic logic [31:0] addi_word(input logic [4:0] rd, input logic [11:0] imm_lo);
        return {imm_lo, rd, 3'b000, rd, OP_IMM};
    endfunction

endpackage

// File: rtl/imm_encoder_pack.sv
// rtl/imm_encoder_pack.sv - imm_pack: immediate range check and field insertion per instruction format
module imm_pack
    import imm_encoder_pkg::*;
#(
    parameter int LEN = 32
) (
    input  logic [5:0]     inst_type,
    input  logic [LEN-1:0] base_inst,
    input  logic [LEN-1:0] immediate,
    output logic [LEN-1:0] instruction,
    output logic           err
);

    logic           fits12;
    logic           fits13;
    logic           fits21;
    logic [LEN-1:0] field;
    logic [LEN-1:0] mask;

    // A value fits an N-bit signed field when all bits from N-1 upward agree
    assign fits12 = (&immediate[31:11]) || !(|immediate[31:11]);
    assign fits13 = (&immediate[31:12]) || !(|immediate[31:12]);
    assign fits21 = (&immediate[31:20]) || !(|immediate[31:20]);

    always_comb begin
        field = '0;
        mask  = '0;
        err   = 1'b0;
        case (inst_type)
            IT_R: err = 1'b0;
            IT_I: begin
                mask[31:20]  = '1;
                field[31:20] = immediate[11:0];
                err          = !fits12;
            end
            IT_S: begin
                mask[31:25]  = '1;
                mask[11:7]   = '1;
                field[31:25] = immediate[11:5];
                field[11:7]  = immediate[4:0];
                err          = !fits12;
            end
            IT_B: begin
                mask[31:25]  = '1;
                mask[11:7]   = '1;
                field[31]    = immediate[12];
                field[30:25] = immediate[10:5];
                field[11:8]  = immediate[4:1];
                field[7]     = immediate[11];
                err          = !fits13 || immediate[0];
            end
            IT_U: begin
                mask[31:12]  = '1;
                field[31:12] = immediate[31:12];
                err          = |immediate[11:0];
            end
            IT_J: begin
                mask[31:12]  = '1;
                field[31]    = immediate[20];
                field[30:21] = immediate[10:1];
                field[20]    = immediate[11];
                field[19:12] = immediate[19:12];
                err          = !fits21 || immediate[0];
            end
            default: err = 1'b1;
        endcase
        instruction = (base_inst & ~mask) | (err ? '0 : field);
    end

endmodule

// File: rtl/imm_encoder.sv
// rtl/imm_encoder.sv - registered immediate encoder with valid/ready handshake
// Optional li (LUI+ADDI) expansion compiled in with IMM_ENCODER_LI_EN.
module imm_encoder
    import imm_encoder_pkg::*;
#(
    parameter int LEN = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [5:0]     inst_type,
    input  logic [LEN-1:0] base_inst,
    input  logic [LEN-1:0] immediate,
    input  logic           in_li,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [LEN-1:0] instruction,
    output logic           err,
    output logic           last
);

    logic [LEN-1:0] pack_inst;
    logic           pack_err;
    logic           accept;
    logic           out_fire;

    logic           out_valid_q, out_valid_d;
    logic [LEN-1:0] instruction_q, instruction_d;
    logic           err_q, err_d;
    logic           last_q, last_d;

    imm_pack #(.LEN(LEN)) u_pack (
        .inst_type   (inst_type),
        .base_inst   (base_inst),
        .immediate   (immediate),
        .instruction (pack_inst),
        .err         (pack_err)
    );

`ifdef IMM_ENCODER_LI_EN
    enc_state_e     state_q, state_d;
    logic [LEN-1:0] addi_q, addi_d;

    assign in_ready = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
`else
    logic unused_in_li;

    assign unused_in_li = in_li;
    assign in_ready     = !out_valid_q || out_ready;
`endif

    assign accept   = in_valid && in_ready;
    assign out_fire = out_valid_q && out_ready;

    always_comb begin
        out_valid_d   = out_valid_q && !out_ready;
        instruction_d = instruction_q;
        err_d         = err_q;
        last_d        = last_q;
`ifdef IMM_ENCODER_LI_EN
        state_d       = state_q;
        addi_d        = addi_q;
        // In LI_LO the presented word is the LUI while last_q is low
        if (state_q == ST_LI_LO) begin
            if (out_fire) begin
                if (!last_q) begin
                    out_valid_d   = 1'b1;
                    instruction_d = addi_q;
                    err_d         = 1'b0;
                    last_d        = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
        end else if (accept && in_li) begin
            out_valid_d   = 1'b1;
            instruction_d = lui_word(base_inst[11:7], immediate[31:11]);
            err_d         = 1'b0;
            last_d        = 1'b0;
            addi_d        = addi_word(base_inst[11:7], immediate[11:0]);
            state_d       = ST_LI_LO;
        end else
`endif
        if (accept) begin
            out_valid_d   = 1'b1;
            instruction_d = pack_inst;
            err_d         = pack_err;
            last_d        = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q   <= 1'b0;
            instruction_q <= '0;
            err_q         <= 1'b0;
            last_q        <= 1'b0;
`ifdef IMM_ENCODER_LI_EN
            state_q       <= ST_IDLE;
            addi_q        <= '0;
`endif
        end else begin
            out_valid_q   <= out_valid_d;
            instruction_q <= instruction_d;
            err_q         <= err_d;
            last_q        <= last_d;
`ifdef IMM_ENCODER_LI_EN
            state_q       <= state_d;
            addi_q        <= addi_d;
`endif
        end
    end

    assign out_valid   = out_valid_q;
    assign instruction = instruction_q;
    assign err         = err_q;
    assign last        = last_q;

endmodule

// File: tb/tb_imm_encoder.sv
// tb/tb_imm_encoder.sv - scoreboard bench for imm_encoder (li cases when IMM_ENCODER_LI_EN is defined)
module tb_imm_encoder;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  inst_type;
    logic [31:0] base_inst;
    logic [31:0] immediate;
    logic        in_li;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instruction;
    logic        err;
    logic        last;

    typedef struct {
        logic [31:0] inst;
        logic        err;
        logic        last;
    } exp_t;

    typedef struct {
        logic [5:0]  t;
        logic [31:0] b;
        logic [31:0] imm;
    } vec_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks;
    int   failures;

    imm_encoder #(.LEN(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .inst_type   (inst_type),
        .base_inst   (base_inst),
        .immediate   (immediate),
        .in_li       (in_li),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .instruction (instruction),
        .err         (err),
        .last        (last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [32:0] model(input logic [5:0] t, input logic [31:0] b, input logic [31:0] imm);
        int          s;
        logic        e;
        logic [31:0] v;
        logic [31:0] r;
        s = $signed(imm);
        r = b;
        case (t)
            6'b100000: e = 1'b0;
            6'b010000, 6'b001000: e = (s < -2048) || (s > 2047);
            6'b000100: e = (s < -4096) || (s > 4094) || imm[0];
            6'b000010: e = (imm[11:0] != 12'h000);
            6'b000001: e = (s < -1048576) || (s > 1048574) || imm[0];
            default:   e = 1'b1;
        endcase
        v = e ? 32'h0 : imm;
        case (t)
            6'b010000: r[31:20] = v[11:0];
            6'b001000: begin r[31:25] = v[11:5]; r[11:7] = v[4:0]; end
            6'b000100: begin r[31] = v[12]; r[30:25] = v[10:5]; r[11:8] = v[4:1]; r[7] = v[11]; end
            6'b000010: r[31:12] = v[31:12];
            6'b000001: begin r[31] = v[20]; r[30:21] = v[10:1]; r[20] = v[11]; r[19:12] = v[19:12]; end
            default: r = b;
        endcase
        return {e, r};
    endfunction

    // Output monitor: every handshaken word must match the head of the scoreboard
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_word got=%08h err=%0b last=%0b expected none", instruction, err, last);
            end else begin
                mon_e = exp_q.pop_front();
                if ({instruction, err, last} !== {mon_e.inst, mon_e.err, mon_e.last}) begin
                    failures++;
                    $display("FAIL word got=%08h/%0b/%0b expected=%08h/%0b/%0b",
                             instruction, err, last, mon_e.inst, mon_e.err, mon_e.last);
                end
            end
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge; returns just after the accepting edge
    task automatic drive(input logic [5:0] t, input logic [31:0] b, input logic [31:0] imm, input logic li,
                         output int waited, output logic ov_at_acc);
        logic [32:0] m;
        logic [31:0] hi;
        exp_t        e;
        in_valid  = 1'b1;
        inst_type = t;
        base_inst = b;
        immediate = imm;
        in_li     = li;
        waited    = 0;
        ov_at_acc = 1'b0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waited++;
            if (waited > 20) begin
                checks++;
                failures++;
                $display("FAIL accept_timeout in_ready=%0b expected 1 within 20 cycles", in_ready);
                in_valid = 1'b0;
                return;
            end
        end
        ov_at_acc = out_valid;
`ifdef IMM_ENCODER_LI_EN
        if (li) begin
            hi = (imm + 32'h800) >> 12;
            e.inst = (hi << 12) | ({27'b0, b[11:7]} << 7) | 32'h37;
            e.err = 1'b0; e.last = 1'b0;
            exp_q.push_back(e);
            e.inst = ({20'b0, imm[11:0]} << 20) | ({27'b0, b[11:7]} << 15) | ({27'b0, b[11:7]} << 7) | 32'h13;
            e.last = 1'b1;
            exp_q.push_back(e);
        end else
`endif
        begin
            m = model(t, b, imm);
            e.inst = m[31:0]; e.err = m[32]; e.last = 1'b1;
            exp_q.push_back(e);
        end
        sync();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; inst_type = 6'b0; base_inst = '0; immediate = '0;
        in_li = 1'b0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        checks += 5;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%0b expected 0", out_valid); end
        if (instruction !== 32'h0) begin failures++; $display("FAIL rst_instruction got=%08h expected 0", instruction); end
        if (err !== 1'b0) begin failures++; $display("FAIL rst_err got=%0b expected 0", err); end
        if (last !== 1'b0) begin failures++; $display("FAIL rst_last got=%0b expected 0", last); end
        if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%0b expected 1", in_ready); end
        sync();
        rst_n = 1'b1;
        sync();
    endtask

    task automatic test_spec_vectors();
        int          w;
        logic        ov;
        logic [5:0]  tv [3];
        logic [31:0] bv [3];
        logic [31:0] iv [3];
        logic [31:0] xi [3];
        logic        xe [3];
        tv[0] = 6'b010000; bv[0] = 32'h00000093; iv[0] = 32'hFFFFFFFF; xi[0] = 32'hFFF00093; xe[0] = 1'b0;
        tv[1] = 6'b000100; bv[1] = 32'h00000063; iv[1] = 32'hFFFFFFFC; xi[1] = 32'hFE000EE3; xe[1] = 1'b0;
        tv[2] = 6'b000100; bv[2] = 32'h00000063; iv[2] = 32'h00000003; xi[2] = 32'h00000063; xe[2] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(tv[i], bv[i], iv[i], 1'b0, w, ov);
            in_valid = 1'b0;
            @(negedge clk);
            checks += 2;
            if (out_valid !== 1'b1) begin failures++; $display("FAIL latency_%0d out_valid=%0b expected 1", i, out_valid); end
            if ({instruction, err, last} !== {xi[i], xe[i], 1'b1}) begin
                failures++;
                $display("FAIL spec_vec_%0d got=%08h/%0b/%0b expected=%08h/%0b/1", i, instruction, err, last, xi[i], xe[i]);
            end
            sync();
        end
    endtask

    task automatic test_formats();
        vec_t v[$];
        int   w;
        logic ov;
        v.push_back('{6'b000010, 32'h00000037, 32'h00001001});
        v.push_back('{6'b110000, 32'h12345678, 32'h00000000});
        v.push_back('{6'b010000, 32'hFFF00093, 32'h00000005});
        v.push_back('{6'b010000, 32'h00000013, 32'd2047});
        v.push_back('{6'b010000, 32'h00000013, 32'hFFFFF800});
        v.push_back('{6'b010000, 32'h00000013, 32'd2048});
        v.push_back('{6'b010000, 32'h00000013, 32'hFFFFF7FF});
        v.push_back('{6'b001000, 32'hFE002FA3, 32'hFFFFFFFD});
        v.push_back('{6'b001000, 32'h00002023, 32'd2048});
        v.push_back('{6'b000100, 32'h00000063, 32'd4094});
        v.push_back('{6'b000100, 32'h00000063, 32'hFFFFF000});
        v.push_back('{6'b000100, 32'h00000063, 32'd4096});
        v.push_back('{6'b000010, 32'hFFFFF0B7, 32'hABCDE000});
        v.push_back('{6'b000001, 32'h0000006F, 32'd1048574});
        v.push_back('{6'b000001, 32'h000000EF, 32'hFFF00000});
        v.push_back('{6'b000001, 32'h0000006F, 32'd1048576});
        v.push_back('{6'b000001, 32'hFFFFF0EF, 32'h00000006});
        v.push_back('{6'b000001, 32'h0000006F, 32'h00000007});
        v.push_back('{6'b100000, 32'h00B50533, 32'hFFFFFFFF});
        v.push_back('{6'b000000, 32'h00000033, 32'h00000010});
        foreach (v[i]) begin
            drive(v[i].t, v[i].b, v[i].imm, 1'b0, w, ov);
            if (i > 0) begin
                checks++;
                if (w !== 0 || ov !== 1'b1) begin
                    failures++;
                    $display("FAIL stream_%0d waited=%0d out_valid=%0b expected 0/1", i, w, ov);
                end
            end
        end
        in_valid = 1'b0;
`ifndef IMM_ENCODER_LI_EN
        drive(6'b010000, 32'h00000293, 32'h12345FFF, 1'b1, w, ov);
        in_valid = 1'b0;
`endif
        repeat (2) sync();
    endtask

    task automatic test_backpressure();
        int          w;
        logic        ov;
        logic [32:0] held;
        held = model(6'b001000, 32'h00002023, 32'h00000123);
        out_ready = 1'b0;
        drive(6'b001000, 32'h00002023, 32'h00000123, 1'b0, w, ov);
        fork
            drive(6'b010000, 32'h00000013, 32'h00000042, 1'b0, w, ov);
            begin
                for (int c = 0; c < 3; c++) begin
                    @(negedge clk);
                    checks += 2;
                    if ({out_valid, instruction, err, last} !== {1'b1, held[31:0], held[32], 1'b1}) begin
                        failures++;
                        $display("FAIL hold_%0d got=%0b/%08h expected=1/%08h", c, out_valid, instruction, held[31:0]);
                    end
                    if (in_ready !== 1'b0) begin failures++; $display("FAIL hold_in_ready_%0d got=%0b expected 0", c, in_ready); end
                end
                sync();
                out_ready = 1'b1;
            end
        join
        for (int k = 0; k < 3; k++) begin
            drive(6'b000001, 32'h0000006F, 32'(k * 8), 1'b0, w, ov);
            checks++;
            if (w !== 0 || ov !== 1'b1) begin
                failures++;
                $display("FAIL b2b_%0d waited=%0d out_valid=%0b expected 0/1", k, w, ov);
            end
        end
        in_valid = 1'b0;
        repeat (2) sync();
    endtask

`ifdef IMM_ENCODER_LI_EN
    task automatic test_li();
        int   w;
        logic ov;
        out_ready = 1'b1;
        drive(6'b000000, 32'h00000280, 32'h12345FFF, 1'b1, w, ov);
        in_valid = 1'b0;
        @(negedge clk);
        checks += 2;
        if ({out_valid, instruction, err, last} !== {1'b1, 32'h123462B7, 1'b0, 1'b0}) begin
            failures++; $display("FAIL li_lui got=%0b/%08h/%0b/%0b expected=1/123462b7/0/0", out_valid, instruction, err, last);
        end
        if (in_ready !== 1'b0) begin failures++; $display("FAIL li_ready_lui got=%0b expected 0", in_ready); end
        @(negedge clk);
        checks += 2;
        if ({out_valid, instruction, err, last} !== {1'b1, 32'hFFF28293, 1'b0, 1'b1}) begin
            failures++; $display("FAIL li_addi got=%0b/%08h/%0b/%0b expected=1/fff28293/0/1", out_valid, instruction, err, last);
        end
        if (in_ready !== 1'b0) begin failures++; $display("FAIL li_ready_addi got=%0b expected 0", in_ready); end
        @(negedge clk);
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            failures++; $display("FAIL li_done out_valid/in_ready got=%0b/%0b expected 0/1", out_valid, in_ready);
        end
        sync();
        drive(6'b010000, 32'h00000A00, 32'h000007FF, 1'b1, w, ov);
        drive(6'b010000, 32'h00000093, 32'hFFFFFFFF, 1'b0, w, ov);
        in_valid = 1'b0;
        repeat (3) sync();
    endtask
`endif

    task automatic test_reset_pending();
        int   w;
        logic ov;
        out_ready = 1'b0;
        drive(6'b010000, 32'h00000280, 32'h12345FFF, 1'b1, w, ov);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks += 2;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_async_valid got=%0b expected 0", out_valid); end
        if ({instruction, err, last} !== 34'h0) begin
            failures++; $display("FAIL rst_async_outputs got=%08h/%0b/%0b expected 0", instruction, err, last);
        end
        exp_q.delete();
        sync();
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_release_in_ready got=%0b expected 1", in_ready); end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_no_addi_%0d out_valid=%0b expected 0", c, out_valid); end
        end
        sync();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_spec_vectors();
        test_formats();
        test_backpressure();
`ifdef IMM_ENCODER_LI_EN
        test_li();
`endif
        test_reset_pending();
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
